vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the brick-breaker display path. It produces the pixel
//  coordinates, active-video flag, syncs and frame/line strobes that the ball,
//  paddle and brick renderers consume. All game objects read x/y/active_pixels
//  from this block, and game logic advances on frame_tick.
// PARAMETERS
//  CLK_DIV   2    clk cycles per pixel (50 MHz clk -> 25 MHz pixel rate); >=1
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_BP      33   vertical back porch, lines
//  SYNC_POL  0    asserted level of hsync/vsync (0 = active-low)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-low reset
//  pix_en         out  1   high 1 clk per pixel period; (div_cnt == CLK_DIV-1)
//  vga_clk        out  1   registered pixel clock, high while div_cnt >= CLK_DIV/2
//  x              out  10  horizontal count 0..H_TOTAL-1
//  y              out  10  vertical count 0..V_TOTAL-1
//  active_pixels  out  1   x < H_ACTIVE && y < V_ACTIVE
//  hsync          out  1   horizontal sync, SYNC_POL while asserted
//  vsync          out  1   vertical sync, SYNC_POL while asserted
//  line_tick      out  1   1-clk pulse when x becomes 0
//  frame_tick     out  1   1-clk pulse when (x,y) becomes (0,V_ACTIVE), i.e. start of vblank
//  vga_blank_n    out  1   equals active_pixels
//  vga_sync_n     out  1   constant 0 (sync-on-green unused)
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both totals
//    must be <=1024 (10-bit counts). This is checked with a synthesis-time assertion.
//  - Reset (async, rst=0): div_cnt=0, x=H_TOTAL-1, y=V_TOTAL-1, active_pixels=0,
//    vga_blank_n=0, hsync=vsync=~SYNC_POL, line_tick=frame_tick=0, vga_clk=0.
//  - div_cnt: counts 0..CLK_DIV-1 every clk and wraps. With CLK_DIV=1, pix_en is constantly 1.
//  - On a clk edge with pix_en=1:
//    - x increments, or wraps to 0 after H_TOTAL-1.
//    - When x wraps, y increments, or wraps to 0 after V_TOTAL-1.
//    - x/y hold between pix_en edges.
//  - hsync, vsync, active_pixels, vga_blank_n, line_tick and frame_tick are registers
//    loaded from the NEXT x/y values. They therefore align with x/y in the same cycle
//    (zero skew).
//  - Sync windows: hsync is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//    = [656,752). vsync is asserted for y in [490,492) over the whole line.
//  - line_tick and frame_tick: high only on the first clk of the pixel period in which
//    the condition becomes true, and low otherwise. frame_tick implies line_tick in
//    the same cycle.
//  - After reset release, the first pix_en edge moves (799,524) -> (0,0). line_tick
//    pulses; frame_tick does not. The first frame_tick arrives at (0,480).
//  - Reset asserted mid-line or mid-frame: all outputs return to reset values
//    immediately (no clk needed). No partial sync pulse is extended.
//  - No inputs other than clk/rst, so no handshakes. The consumer samples x/y on any
//    clk; values are stable for CLK_DIV clks.
// STRUCTURE
//  - Package vga_timing_pkg: default 640x480@60 porch/sync constants, H_TOTAL/V_TOTAL
//    functions, SYNC_POL default, coordinate width (10). This package is shared with
//    the ball, paddle and brick renderers.
//  - Sub-module vga_axis_counter(MAX, SYNC_START, SYNC_END, ACTIVE): a wrapping counter
//    with enable, a wrap flag, and a next-value window decode. It is instantiated once
//    for h and once for v; the v enable is h_en & h_wrap.
// TESTING
//  1. Reset release, default params: x=799, y=524, hsync=vsync=1, active=0. Two clks
//     later, x=0, y=0, active=1, and line_tick is high for exactly 1 clk.
//  2. One line: line_tick period = 1600 clk. hsync is low for exactly 192 clk
//     (x=656..751). Active is high for 1280 clk per line.
//  3. One frame: frame_tick period = 840000 clk and fires with x=0, y=480. vsync is low
//     for 3200 clk (y=490..491). Exactly 307200 pixel periods per frame have active=1.
//     vga_blank_n == active_pixels on every clk.
//  4. Reset mid-frame at (x=300, y=100): outputs go to reset values asynchronously.
//     After release, timing restarts at (0,0) with the same periods as test 3.
//  5. CLK_DIV=1, SYNC_POL=1: pix_en stuck at 1. Frame period = 420000 clk. hsync and
//     vsync are high only inside their windows.
//  6. Wrap corner: at (799,524) -> (0,0), line_tick=1, frame_tick=0, y wraps in the same
//     edge as x, and no extra cycle or glitch occurs on hsync/vsync.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the display path.
// Used by the timing generator and by every renderer reading x/y.
package vga_timing_pkg;

    localparam int COORD_W     = 10;
    localparam int COORD_LIMIT = 1 << COORD_W;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic DEF_SYNC_POL = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic active;
        logic blank_n;
        logic hsync;
        logic vsync;
        logic line_tick;
        logic frame_tick;
    } vga_ctl_t;

    function automatic int axis_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic bit fits_coord(input int total);
        return (total >= 2) && (total <= COORD_LIMIT);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, wrap flag and
// decode of the value the counter is about to take.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int W          = COORD_W,
    parameter int MAX        = 799,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int ACTIVE     = 640
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic [W-1:0] nxt,
    output logic         sync_nxt,
    output logic         act_nxt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W:0]   SS_V  = (W+1)'(SYNC_START);
    localparam logic [W:0]   SE_V  = (W+1)'(SYNC_END);
    localparam logic [W:0]   ACT_V = (W+1)'(ACTIVE);

    logic [W:0] nxt_ext;

    assign wrap    = (cnt == MAX_V);
    assign nxt_ext = {1'b0, nxt};

    // Next count: step on enable, fold back to zero after MAX.
    always_comb begin
        nxt = cnt;
        if (en) begin
            if (wrap) begin
                nxt = '0;
            end else begin
                nxt = cnt + 1'b1;
            end
        end
    end

    assign sync_nxt = (nxt_ext >= SS_V) && (nxt_ext < SE_V);
    assign act_nxt  = (nxt_ext < ACT_V);

    // Count register; reset parks on MAX so the first step lands on 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= MAX_V;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel strobe, x/y, syncs, active flag and
// line/frame ticks, all registered and aligned with x/y.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic       vga_clk,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active_pixels,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
    output logic       frame_tick,
    output logic       vga_blank_n,
    output logic       vga_sync_n
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam int H_SS = H_ACTIVE + H_FP;
    localparam int H_SE = H_SS + H_SYNC;
    localparam int V_SS = V_ACTIVE + V_FP;
    localparam int V_SE = V_SS + V_SYNC;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW:0]   DIV_HALF = (DW+1)'(CLK_DIV / 2);

    localparam coord_t V_ACT_C = COORD_W'(V_ACTIVE);

    localparam vga_ctl_t CTL_RST = '{
        active:     1'b0,
        blank_n:    1'b0,
        hsync:      ~SYNC_POL,
        vsync:      ~SYNC_POL,
        line_tick:  1'b0,
        frame_tick: 1'b0
    };

    if (!fits_coord(H_TOTAL)) begin : g_bad_h
        $error("H_TOTAL does not fit the 10-bit coordinate");
    end

    if (!fits_coord(V_TOTAL)) begin : g_bad_v
        $error("V_TOTAL does not fit the 10-bit coordinate");
    end

    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end

    if (V_ACTIVE >= V_TOTAL || H_ACTIVE >= H_TOTAL) begin : g_bad_act
        $error("blanking interval must be non-empty");
    end

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic          vga_clk_nxt;

    logic   h_wrap;
    logic   h_sync_nxt;
    logic   h_act_nxt;
    coord_t h_nxt;

    logic   v_en;
    logic   v_wrap_unused;
    logic   v_sync_nxt;
    logic   v_act_nxt;
    coord_t v_nxt;

    logic   h_step;
    logic   at_vblank;

    vga_ctl_t ctl_nxt;
    vga_ctl_t ctl_q;

    assign pix_en = (div_cnt == DIV_LAST);

    assign div_nxt     = pix_en ? '0 : div_cnt + 1'b1;
    assign vga_clk_nxt = ({1'b0, div_nxt} >= DIV_HALF);

    // Pixel divider and registered pixel clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            vga_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            vga_clk <= vga_clk_nxt;
        end
    end

    vga_axis_counter #(
        .W          (COORD_W),
        .MAX        (H_TOTAL - 1),
        .SYNC_START (H_SS),
        .SYNC_END   (H_SE),
        .ACTIVE     (H_ACTIVE)
    ) u_h (
        .clk      (clk),
        .rst      (rst),
        .en       (pix_en),
        .cnt      (x),
        .wrap     (h_wrap),
        .nxt      (h_nxt),
        .sync_nxt (h_sync_nxt),
        .act_nxt  (h_act_nxt)
    );

    assign h_step = pix_en & h_wrap;
    assign v_en   = h_step;

    vga_axis_counter #(
        .W          (COORD_W),
        .MAX        (V_TOTAL - 1),
        .SYNC_START (V_SS),
        .SYNC_END   (V_SE),
        .ACTIVE     (V_ACTIVE)
    ) u_v (
        .clk      (clk),
        .rst      (rst),
        .en       (v_en),
        .cnt      (y),
        .wrap     (v_wrap_unused),
        .nxt      (v_nxt),
        .sync_nxt (v_sync_nxt),
        .act_nxt  (v_act_nxt)
    );

    assign at_vblank = (v_nxt == V_ACT_C);

    // Decode of the upcoming x/y so the registered flags line up with x/y.
    always_comb begin
        ctl_nxt            = CTL_RST;
        ctl_nxt.active     = h_act_nxt & v_act_nxt;
        ctl_nxt.blank_n    = h_act_nxt & v_act_nxt;
        ctl_nxt.hsync      = h_sync_nxt ? SYNC_POL : ~SYNC_POL;
        ctl_nxt.vsync      = v_sync_nxt ? SYNC_POL : ~SYNC_POL;
        ctl_nxt.line_tick  = h_step;
        ctl_nxt.frame_tick = h_step & at_vblank;
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_q <= CTL_RST;
        end else begin
            ctl_q <= ctl_nxt;
        end
    end

    assign active_pixels = ctl_q.active;
    assign vga_blank_n   = ctl_q.blank_n;
    assign hsync         = ctl_q.hsync;
    assign vsync         = ctl_q.vsync;
    assign line_tick     = ctl_q.line_tick;
    assign frame_tick    = ctl_q.frame_tick;
    assign vga_sync_n    = 1'b0;

    logic h_nxt_unused;
    assign h_nxt_unused = ^h_nxt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three generator configurations against a linear-index raster model,
// with randomized run lengths and asynchronous resets.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pix_en;
        logic       vga_clk;
        logic       act;
        logic       hs;
        logic       vs;
        logic       lt;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;
    int k = 0;

    always #5 clk = ~clk;

    // Config A: tiny raster, divide by 2, active-low syncs.
    logic       a_pe, a_vc, a_ap, a_hs, a_vs, a_lt, a_ft, a_bn, a_sn;
    logic [9:0] a_x, a_y;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) u_a (
        .clk(clk), .rst(rst), .pix_en(a_pe), .vga_clk(a_vc),
        .x(a_x), .y(a_y), .active_pixels(a_ap), .hsync(a_hs),
        .vsync(a_vs), .line_tick(a_lt), .frame_tick(a_ft),
        .vga_blank_n(a_bn), .vga_sync_n(a_sn)
    );

    // Config B: tiny raster, no divide, active-high syncs.
    logic       b_pe, b_vc, b_ap, b_hs, b_vs, b_lt, b_ft, b_bn, b_sn;
    logic [9:0] b_x, b_y;

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(10), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(b_pe), .vga_clk(b_vc),
        .x(b_x), .y(b_y), .active_pixels(b_ap), .hsync(b_hs),
        .vsync(b_vs), .line_tick(b_lt), .frame_tick(b_ft),
        .vga_blank_n(b_bn), .vga_sync_n(b_sn)
    );

    // Config C: default 640x480 timing.
    logic       c_pe, c_vc, c_ap, c_hs, c_vs, c_lt, c_ft, c_bn, c_sn;
    logic [9:0] c_x, c_y;

    vga_timing_gen u_c (
        .clk(clk), .rst(rst), .pix_en(c_pe), .vga_clk(c_vc),
        .x(c_x), .y(c_y), .active_pixels(c_ap), .hsync(c_hs),
        .vsync(c_vs), .line_tick(c_lt), .frame_tick(c_ft),
        .vga_blank_n(c_bn), .vga_sync_n(c_sn)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %0d exp %0d", tag, k, got, exp);
        end
    endtask

    // Position after k clk edges since reset release: the raster is a
    // linear pixel index starting one before (0,0), advanced once per
    // CLK_DIV edges.
    function automatic exp_t model(
        input int kk, input int d,
        input int ha, input int hf, input int hsw, input int hb,
        input int va, input int vf, input int vsw, input int vb,
        input bit pol
    );
        exp_t e;
        int ht, vt, n, lin, xx, yy, ph;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        n   = kk / d;
        ph  = kk % d;
        lin = (ht * vt - 1 + n) % (ht * vt);
        xx  = lin % ht;
        yy  = lin / ht;
        e.x       = 10'(xx);
        e.y       = 10'(yy);
        e.pix_en  = (ph == d - 1);
        e.vga_clk = (kk > 0) && (ph >= d / 2);
        e.act     = (xx < ha) && (yy < va);
        e.hs      = (xx >= ha + hf && xx < ha + hf + hsw) ? pol : !pol;
        e.vs      = (yy >= va + vf && yy < va + vf + vsw) ? pol : !pol;
        e.lt      = (kk > 0) && (ph == 0) && (xx == 0);
        e.ft      = e.lt && (yy == va);
        return e;
    endfunction

    task automatic check_dut(
        input string nm, input exp_t e,
        input logic [9:0] gx, input logic [9:0] gy,
        input logic pe, input logic vc, input logic ap,
        input logic hs, input logic vs, input logic lt,
        input logic ft, input logic bn, input logic sn
    );
        chk({nm, ".x"}, 32'(gx), 32'(e.x));
        chk({nm, ".y"}, 32'(gy), 32'(e.y));
        chk({nm, ".pix_en"}, 32'(pe), 32'(e.pix_en));
        chk({nm, ".vga_clk"}, 32'(vc), 32'(e.vga_clk));
        chk({nm, ".active"}, 32'(ap), 32'(e.act));
        chk({nm, ".hsync"}, 32'(hs), 32'(e.hs));
        chk({nm, ".vsync"}, 32'(vs), 32'(e.vs));
        chk({nm, ".line_tick"}, 32'(lt), 32'(e.lt));
        chk({nm, ".frame_tick"}, 32'(ft), 32'(e.ft));
        chk({nm, ".blank_n"}, 32'(bn), 32'(e.act));
        chk({nm, ".sync_n"}, 32'(sn), 32'd0);
    endtask

    task automatic check_all(input int kk);
        check_dut("A", model(kk, 2, 16, 2, 3, 2, 6, 1, 2, 1, 1'b0),
                  a_x, a_y, a_pe, a_vc, a_ap, a_hs, a_vs,
                  a_lt, a_ft, a_bn, a_sn);
        check_dut("B", model(kk, 1, 10, 1, 2, 3, 5, 2, 1, 2, 1'b1),
                  b_x, b_y, b_pe, b_vc, b_ap, b_hs, b_vs,
                  b_lt, b_ft, b_bn, b_sn);
        check_dut("C", model(kk, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
                  c_x, c_y, c_pe, c_vc, c_ap, c_hs, c_vs,
                  c_lt, c_ft, c_bn, c_sn);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            check_all(k);
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        #1 rst = 1'b1;
        k = 0;
        check_all(0);
    endtask

    initial begin
        rst = 1'b0;
        k = 0;
        repeat (3) @(negedge clk);
        check_all(0);
        release_rst();
        run(1700);
        for (int r = 0; r < 8; r++) begin
            @(posedge clk);
            #2 rst = 1'b0;
            k = 0;
            #1 check_all(0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_rst();
            run($urandom_range(50, 1200));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog k=%0d got timeout exp finish", k);
        $fatal(1, "timeout");
    end

endmodule
